// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage and integer register file.
//   Picks the ALU result or the loaded word (with byte/half extraction and
//   sign/zero extension), writes it into the register file, serves the two
//   decode read ports with same-cycle write-through bypass, and counts
//   retired instructions.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low
//   wb_control_sig [0] reg_write, [1] mem_to_reg, [4:2] load funct3,
//                  [5] valid (retires), [9:6] unused
//   wb_memval      aligned word read from data memory
//   wb_alu         ALU result; byte address for loads
//   wb_rd          destination register index
//   rs1_addr/rs2_addr, rs1_data/rs2_data   decode read ports (combinational)
//   wb_wdata       final write-back value (combinational)
//   wb_we          effective write enable (reg_write and rd != 0)
//   instret        retired-instruction count (registered)
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       wb_control_sig,
  input  logic [XLEN-1:0]  wb_memval,
  input  logic [XLEN-1:0]  wb_alu,
  input  logic [AW-1:0]    wb_rd,
  input  logic [AW-1:0]    rs1_addr,
  input  logic [AW-1:0]    rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  output logic [XLEN-1:0]  wb_wdata,
  output logic             wb_we,
  output logic [CNT_W-1:0] instret
);

  logic       reg_write;
  logic       mem_to_reg;
  logic [2:0] funct3;
  logic       valid;
  logic [1:0] off;
  logic [3:0] unused_ctrl;

  assign reg_write   = wb_control_sig[0];
  assign mem_to_reg  = wb_control_sig[1];
  assign funct3      = wb_control_sig[4:2];
  assign valid       = wb_control_sig[5];
  assign unused_ctrl = wb_control_sig[9:6];
  assign off         = wb_alu[1:0];

  logic [XLEN-1:0] regs_q [NREG];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;

  // Load extraction
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [XLEN-1:0] load_val;

  always_comb begin
    byte_sel = wb_memval[7:0];
    case (off)
      2'd0: byte_sel = wb_memval[7:0];
      2'd1: byte_sel = wb_memval[15:8];
      2'd2: byte_sel = wb_memval[23:16];
      2'd3: byte_sel = wb_memval[31:24];
      default: byte_sel = wb_memval[7:0];
    endcase
    // off[0] is deliberately ignored for halfword loads.
    half_sel = off[1] ? wb_memval[31:16] : wb_memval[15:0];

    load_val = wb_memval;
    case (funct3)
      3'b000: load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b100: load_val = {{(XLEN-8){1'b0}}, byte_sel};
      3'b001: load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b101: load_val = {{(XLEN-16){1'b0}}, half_sel};
      default: load_val = wb_memval;
    endcase
  end

  assign wb_wdata = mem_to_reg ? load_val : wb_alu;
  assign wb_we    = reg_write && (wb_rd != '0);

  // Register file; x0 is never written because wb_we excludes rd == 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_we) begin
      regs_q[wb_rd] <= wb_wdata;
    end
  end

  assign instret_d = valid ? instret_q + 1'b1 : instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) instret_q <= '0;
    else      instret_q <= instret_d;
  end

  assign instret = instret_q;

  // Bypass is gated by rst so that the read ports show 0 throughout reset,
  // even if a write is presented while reset is held.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) rs1_data = regs_q[rs1_addr];
    if (rst && wb_we && (wb_rd == rs1_addr)) rs1_data = wb_wdata;

    rs2_data = '0;
    if (rs2_addr != '0) rs2_data = regs_q[rs2_addr];
    if (rst && wb_we && (wb_rd == rs2_addr)) rs2_data = wb_wdata;
  end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [9:0]  wb_control_sig;
  logic [31:0] wb_memval;
  logic [31:0] wb_alu;
  logic [4:0]  wb_rd;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_wdata;
  logic        wb_we;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .wb_control_sig (wb_control_sig),
    .wb_memval      (wb_memval),
    .wb_alu         (wb_alu),
    .wb_rd          (wb_rd),
    .rs1_addr       (rs1_addr),
    .rs2_addr       (rs2_addr),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .wb_wdata       (wb_wdata),
    .wb_we          (wb_we),
    .instret        (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // control word: valid, funct3, mem_to_reg, reg_write
  function automatic logic [9:0] ctl(input logic v, input logic [2:0] f3,
                                     input logic m2r, input logic rw);
    return {4'b0000, v, f3, m2r, rw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] exp;
    string       tag;
  } ld_vec_t;

  ld_vec_t ld_vecs[$];
  logic [9:0] vpat;

  initial begin
    rst = 1'b0;
    wb_control_sig = '0;
    wb_memval = '0;
    wb_alu = '0;
    wb_rd = '0;
    rs1_addr = '0;
    rs2_addr = '0;

    // 1. reset state
    #2;
    chk("reset_instret", instret, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      chk($sformatf("reset_rs1_x%0d", i), {32'd0, rs1_data}, 64'd0);
      chk($sformatf("reset_rs2_x%0d", 31 - i), {32'd0, rs2_data}, 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    rs1_addr = 5'd17; rs2_addr = 5'd31;
    #1;
    chk("post_reset_rs1", {32'd0, rs1_data}, 64'd0);
    chk("post_reset_rs2", {32'd0, rs2_data}, 64'd0);

    // 2. ALU write to x5, then attempt to write x0
    wb_control_sig = ctl(1'b1, 3'b000, 1'b0, 1'b1);
    wb_rd = 5'd5; wb_alu = 32'h1234_5678; rs1_addr = 5'd1; rs2_addr = 5'd2;
    #1;
    chk("alu_wdata", {32'd0, wb_wdata}, 64'h1234_5678);
    chk("alu_we", {63'd0, wb_we}, 64'd1);
    tick();
    wb_control_sig = '0;
    rs1_addr = 5'd5;
    #1;
    chk("x5_readback", {32'd0, rs1_data}, 64'h1234_5678);

    wb_control_sig = ctl(1'b1, 3'b000, 1'b0, 1'b1);
    wb_rd = 5'd0; wb_alu = 32'hFFFF_FFFF; rs1_addr = 5'd0; rs2_addr = 5'd5;
    #1;
    chk("x0_we", {63'd0, wb_we}, 64'd0);
    chk("x0_no_bypass", {32'd0, rs1_data}, 64'd0);
    tick();
    wb_control_sig = '0;
    #1;
    chk("x0_stays_zero", {32'd0, rs1_data}, 64'd0);
    chk("x5_kept", {32'd0, rs2_data}, 64'h1234_5678);

    // 3. load extraction
    wb_memval = 32'h80FF_7F01;
    ld_vecs.push_back('{3'b000, 2'd3, 32'hFFFF_FF80, "lb_off3"});
    ld_vecs.push_back('{3'b100, 2'd3, 32'h0000_0080, "lbu_off3"});
    ld_vecs.push_back('{3'b000, 2'd0, 32'h0000_0001, "lb_off0"});
    ld_vecs.push_back('{3'b000, 2'd1, 32'h0000_007F, "lb_off1"});
    ld_vecs.push_back('{3'b000, 2'd2, 32'hFFFF_FFFF, "lb_off2"});
    ld_vecs.push_back('{3'b100, 2'd2, 32'h0000_00FF, "lbu_off2"});
    ld_vecs.push_back('{3'b001, 2'd2, 32'hFFFF_80FF, "lh_off2"});
    ld_vecs.push_back('{3'b001, 2'd3, 32'hFFFF_80FF, "lh_off3"});
    ld_vecs.push_back('{3'b001, 2'd0, 32'h0000_7F01, "lh_off0"});
    ld_vecs.push_back('{3'b101, 2'd1, 32'h0000_7F01, "lhu_off1"});
    ld_vecs.push_back('{3'b101, 2'd2, 32'h0000_80FF, "lhu_off2"});
    ld_vecs.push_back('{3'b010, 2'd2, 32'h80FF_7F01, "lw_off2"});
    ld_vecs.push_back('{3'b011, 2'd1, 32'h80FF_7F01, "f3_011"});
    ld_vecs.push_back('{3'b110, 2'd3, 32'h80FF_7F01, "f3_110"});
    ld_vecs.push_back('{3'b111, 2'd0, 32'h80FF_7F01, "f3_111"});
    foreach (ld_vecs[k]) begin
      wb_control_sig = ctl(1'b0, ld_vecs[k].f3, 1'b1, 1'b0);
      wb_alu = {30'h0000_1000, ld_vecs[k].off};
      #1;
      chk(ld_vecs[k].tag, {32'd0, wb_wdata}, {32'd0, ld_vecs[k].exp});
    end
    // a load that actually lands in x9
    wb_control_sig = ctl(1'b1, 3'b000, 1'b1, 1'b1);
    wb_alu = 32'h0000_2003; wb_rd = 5'd9;
    tick();
    wb_control_sig = '0;
    rs1_addr = 5'd9;
    #1;
    chk("x9_lb_written", {32'd0, rs1_data}, 64'hFFFF_FF80);

    // 4. dual-port bypass
    wb_control_sig = ctl(1'b1, 3'b000, 1'b0, 1'b1);
    wb_rd = 5'd7; wb_alu = 32'hDEAD_BEEF; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    chk("bypass_rs1", {32'd0, rs1_data}, 64'hDEAD_BEEF);
    chk("bypass_rs2", {32'd0, rs2_data}, 64'hDEAD_BEEF);
    tick();
    // same rd but reg_write=0: no bypass, no write
    wb_control_sig = ctl(1'b0, 3'b000, 1'b0, 1'b0);
    wb_alu = 32'h1111_2222;
    #1;
    chk("nobypass_rs1", {32'd0, rs1_data}, 64'hDEAD_BEEF);
    tick();
    chk("x7_unchanged", {32'd0, rs2_data}, 64'hDEAD_BEEF);

    // mid-run asynchronous reset, with a write presented during reset
    rs1_addr = 5'd7; rs2_addr = 5'd5;
    wb_control_sig = ctl(1'b1, 3'b000, 1'b0, 1'b1);
    wb_rd = 5'd7; wb_alu = 32'hCAFE_F00D;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_rs1", {32'd0, rs1_data}, 64'd0);
    chk("async_rst_rs2", {32'd0, rs2_data}, 64'd0);
    chk("async_rst_instret", instret, 64'd0);
    tick();
    wb_control_sig = '0;
    rst = 1'b1;
    #1;
    chk("write_lost_in_rst", {32'd0, rs1_data}, 64'd0);
    chk("rst_instret_held", instret, 64'd0);

    // 5. instret: 10 cycles, valid on 7, reg_write toggled independently
    vpat = 10'b1011011011;
    for (int c = 0; c < 10; c++) begin
      wb_control_sig = ctl(vpat[c], 3'b000, 1'b0, ~vpat[c]);
      wb_rd = 5'd0;
      tick();
    end
    wb_control_sig = '0;
    #1;
    chk("instret_7", instret, 64'd7);

    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    release dut.instret_d;
    #1;
    chk("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    wb_control_sig = ctl(1'b1, 3'b000, 1'b0, 1'b0);
    tick();
    wb_control_sig = '0;
    #1;
    chk("instret_wrap", instret, 64'd0);
    tick();
    chk("instret_idle", instret, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
